// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential 16x16 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mult_pkg;

    // Operand width; the product is twice as wide.
    localparam int WIDTH = 16;

    // Iteration counter width: must hold 0..WIDTH-1.
    localparam int CNT_W = 5;

    // Product width.
    localparam int PW = 2 * WIDTH;

    // Counter value seen during the last CALC cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add16_rc.sv
// 16-bit ripple-carry adder with carry out, half adder at bit 0.
// Latency: combinational, one ripple chain.
// Backpressure: none.
module add16_rc
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry out.
    logic [WIDTH:1] w_carry;

    // Bit 0 has no carry in, so a half adder suffices.
    half_adder u_ha0 (
        .i_a    (i_a[0]),
        .i_b    (i_b[0]),
        .o_sum  (o_sum[0]),
        .o_cout (w_carry[1])
    );

    // Bits 1..WIDTH-1 ripple the carry upward.
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_fa
        full_adder u_fa (
            .i_a    (i_a[gi]),
            .i_b    (i_b[gi]),
            .i_cin  (w_carry[gi]),
            .o_sum  (o_sum[gi]),
            .o_cout (w_carry[gi+1])
        );
    end

    assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/mult_cells.sv
// Single-bit adder cells used to build the ripple-carry adder.
// Latency: combinational.
// Backpressure: none.

// Half adder: sum and carry of two bits.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b;
    assign o_cout = i_a & i_b;

endmodule

// Full adder: sum and carry of two bits plus a carry in.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_p;

    assign w_p    = i_a ^ i_b;
    assign o_sum  = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (w_p & i_cin);

endmodule

// File: rtl/mult16x16_seq.sv
// Iterative radix-2 shift-add unsigned 16x16 multiplier, one adder reused 16 times.
// Latency: accept edge is cycle 0, product valid after edge 16; 18 cycles per product minimum.
// Backpressure: in_ready only in IDLE; DONE holds p stable until out_ready.
module mult16x16_seq
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    p,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    // The multiplicand is added only when the multiplier bit now at acc[0] is set.
    assign w_addend = r_acc[0] ? r_mcand : '0;

    add16_rc u_add (
        .i_a    (r_acc[PW-1:WIDTH]),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register; reset abandons any in-flight product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, 16 iterations in CALC, wait for consumer in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then add-and-shift right once per CALC cycle.
    // The adder carry becomes the new MSB, so no product bit is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_acc   <= {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_acc <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                    // DONE holds the product until the next accept.
                end
            endcase
        end
    end

    // Handshake outputs come from registered state only.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == CALC);
    assign p         = r_acc;

endmodule

// File: tb/tb_mult16x16_seq.sv
// Self-checking bench for mult16x16_seq: directed steps then randomized scoreboard run.
// Latency: expects product 16 edges after accept.
// Backpressure: exercises out_ready stalls and ignored in_valid outside IDLE.
module tb_mult16x16_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mult16x16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge in IDLE; returns one negedge after the accept edge.
    task automatic start(input logic [15:0] ta, input logic [15:0] tb_op);
        a = ta;
        b = tb_op;
        in_valid = 1'b1;
        chk("start_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_in_ready_drop", 32'(in_ready), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
    endtask

    // Wait for out_valid, counting edges since accept and busy cycles.
    task automatic wait_done(input logic [31:0] exp, input bit junk, input string tag);
        int lat   = 0;
        int nbusy = 0;
        while (!out_valid && lat < 200) begin
            if (busy) nbusy++;
            if (junk) begin
                in_valid = 1'($urandom % 2);
                a = 16'($urandom);
                b = 16'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd16);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_p"}, p, exp);
    endtask

    // Consume the product; DONE->IDLE takes exactly one edge.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 8)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    localparam int N_RAND    = 1500;
    localparam int CYC_LIMIT = 60000;

    logic [31:0] q[$];
    logic [31:0] last_p;
    logic [31:0] exp_p;
    bit          stall_prev;
    int          accepts;
    int          outs;
    int          cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p", p, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3 * 5.
        start(16'd3, 16'd5);
        wait_done(32'h0000000F, 1'b0, "t3x5");
        finish_op("t3x5");

        // Maximum operands with out_ready tied high: out_valid lasts one cycle.
        out_ready = 1'b1;
        start(16'hFFFF, 16'hFFFF);
        wait_done(32'hFFFE0001, 1'b0, "tmax");
        finish_op("tmax");

        // Zero operands keep full latency.
        start(16'h1234, 16'h0000);
        wait_done(32'h0, 1'b0, "tzero_b");
        finish_op("tzero_b");
        start(16'h0000, 16'hABCD);
        wait_done(32'h0, 1'b0, "tzero_a");
        finish_op("tzero_a");

        // Long stall with in_valid and operands toggling during CALC and DONE.
        start(16'h00FF, 16'h0100);
        wait_done(32'h0000FF00, 1'b1, "tstall");
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'($urandom % 2);
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            chk("tstall_p_hold", p, 32'h0000FF00);
        end
        chk("tstall_out_valid_hold", 32'(out_valid), 32'd1);
        chk("tstall_in_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        finish_op("tstall");

        // Reset during CALC cycle 7.
        start(16'hBEEF, 16'hCAFE);
        repeat (7) @(negedge clk);
        chk("trst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("trst_in_ready", 32'(in_ready), 32'd1);
        chk("trst_out_valid", 32'(out_valid), 32'd0);
        chk("trst_busy", 32'(busy), 32'd0);
        chk("trst_p", p, 32'd0);
        start(16'd7, 16'd9);
        wait_done(32'h0000003F, 1'b0, "t7x9");
        finish_op("t7x9");

        // Randomized traffic against a queue-based reference.
        accepts    = 0;
        outs       = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        last_p     = '0;
        while ((accepts < N_RAND || q.size() != 0) && cyc < CYC_LIMIT) begin
            out_ready = (($urandom % 3) != 0);
            if (out_valid) begin
                if (stall_prev) chk("rand_p_stable", p, last_p);
                if (out_ready) begin
                    chk("rand_one_in_flight", 32'(q.size()), 32'd1);
                    if (q.size() != 0) begin
                        exp_p = q.pop_front();
                        chk("rand_product", p, exp_p);
                    end
                    outs++;
                end
                stall_prev = !out_ready;
                last_p     = p;
            end else begin
                stall_prev = 1'b0;
            end
            in_valid = (accepts < N_RAND) && (($urandom % 4) != 0);
            a = pick();
            b = pick();
            if (in_valid && in_ready) begin
                q.push_back(32'(a) * 32'(b));
                accepts++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_no_timeout", 32'(cyc < CYC_LIMIT), 32'd1);
        chk("rand_accepts", 32'(accepts), 32'(N_RAND));
        chk("rand_outputs", 32'(outs), 32'(N_RAND));
        chk("rand_queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
